// File: rtl/ss_pkt_fifo_sync.sv
// ss_pkt_fifo_sync: single-clock, frame-aware FIFO with commit/rollback.
// A frame becomes readable only after its eof word is written good. Bad or
// overflowing frames are rewound to the last commit point and counted.
// Read side is first-word-fall-through through a two-stage pipe (memory read
// register, then output register).
// Handshake: a word moves out when rd_vld & rd_en are both high on a rising
// edge; while rd_vld & ~rd_en the output word and flags hold steady.
module ss_pkt_fifo_sync #(
    parameter int Bw_d    = 8,
    parameter int Bw_a    = 10,
    parameter int Thrs_wr = (1 << Bw_a) / 4 * 3,
    parameter int Bw_c    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [Bw_d-1:0] wr_di,
    input  logic            wr_en,
    input  logic            wr_eof,
    input  logic            wr_bad,
    output logic            wr_rdy,
    output logic [Bw_d-1:0] rd_do,
    output logic            rd_eof,
    output logic            rd_vld,
    input  logic            rd_en,
    output logic [Bw_a:0]   frm_cnt,
    output logic [Bw_c-1:0] drp_cnt
);

    localparam int Depth = 1 << Bw_a;
    localparam logic [Bw_a:0] DepthC = {1'b1, {Bw_a{1'b0}}};
    localparam logic [Bw_a:0] ThrsC  = (Bw_a + 1)'(Thrs_wr);
    localparam logic [Bw_a:0] OneA   = 1;
    localparam logic [Bw_c-1:0] OneC = 1;

    // Storage word is {eof, data}.
    logic [Bw_d:0]   mem_q [Depth];

    logic [Bw_a:0]   wr_ad_q, wr_ad_d;
    logic [Bw_a:0]   cm_ad_q, cm_ad_d;
    logic [Bw_a:0]   rd_ad_q, rd_ad_d;
    logic            ovf_q, ovf_d;
    logic [Bw_a:0]   frm_cnt_q, frm_cnt_d;
    logic [Bw_c-1:0] drp_cnt_q, drp_cnt_d;
    logic            s1_vld_q, s1_vld_d;
    logic [Bw_d:0]   s1_dat_q;
    logic            out_vld_q, out_vld_d;
    logic [Bw_d:0]   out_dat_q, out_dat_d;

    logic [Bw_a:0]   used;
    logic            full;
    logic            wr_store;
    logic            frm_end;
    logic            commit;
    logic            drop;
    logic            xfer_eof;
    logic            out_free;
    logic            s1_free;
    logic            fetch;

    // Occupancy, write qualification and read-pipe flow control.
    always_comb begin
        used     = wr_ad_q - rd_ad_q;
        full     = (used == DepthC);
        wr_store = wr_en & ~full & ~ovf_q;
        frm_end  = wr_en & wr_eof;
        commit   = frm_end & wr_store & ~wr_bad;
        drop     = frm_end & ~commit;
        xfer_eof = out_vld_q & rd_en & out_dat_q[Bw_d];
        out_free = ~out_vld_q | rd_en;
        s1_free  = ~s1_vld_q | out_free;
        // Never fetch past the commit boundary.
        fetch    = (rd_ad_q != cm_ad_q) & s1_free;
    end

    // Next-state for pointers, overflow flag, counters and the output pipe.
    always_comb begin
        wr_ad_d   = wr_ad_q;
        cm_ad_d   = cm_ad_q;
        ovf_d     = ovf_q;
        drp_cnt_d = drp_cnt_q;
        frm_cnt_d = frm_cnt_q;
        rd_ad_d   = rd_ad_q;
        s1_vld_d  = s1_vld_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        if (drop) begin
            // Rewind to the last commit; the frame's space is free next cycle.
            wr_ad_d = cm_ad_q;
            ovf_d   = 1'b0;
            if (drp_cnt_q != {Bw_c{1'b1}}) begin
                drp_cnt_d = drp_cnt_q + OneC;
            end
        end else if (wr_store) begin
            wr_ad_d = wr_ad_q + OneA;
            if (commit) begin
                cm_ad_d = wr_ad_q + OneA;
            end
        end else if (wr_en) begin
            // Mid-frame word that found the buffer full (or frame already lost).
            ovf_d = 1'b1;
        end

        case ({commit, xfer_eof})
            2'b10:   frm_cnt_d = frm_cnt_q + OneA;
            2'b01:   frm_cnt_d = frm_cnt_q - OneA;
            default: frm_cnt_d = frm_cnt_q;
        endcase

        if (fetch) begin
            rd_ad_d = rd_ad_q + OneA;
        end
        s1_vld_d = fetch | (s1_vld_q & ~out_free);

        if (out_free) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_dat_d = s1_dat_q;
            end
        end
    end

    // Control state and output register, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ad_q   <= '0;
            cm_ad_q   <= '0;
            rd_ad_q   <= '0;
            ovf_q     <= 1'b0;
            frm_cnt_q <= '0;
            drp_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            wr_ad_q   <= wr_ad_d;
            cm_ad_q   <= cm_ad_d;
            rd_ad_q   <= rd_ad_d;
            ovf_q     <= ovf_d;
            frm_cnt_q <= frm_cnt_d;
            drp_cnt_q <= drp_cnt_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    // Storage array: synchronous write, registered read into stage 1.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem_q[wr_ad_q[Bw_a-1:0]] <= {wr_eof, wr_di};
        end
        if (fetch) begin
            s1_dat_q <= mem_q[rd_ad_q[Bw_a-1:0]];
        end
    end

    assign wr_rdy  = (used <= ThrsC);
    assign rd_do   = out_dat_q[Bw_d-1:0];
    assign rd_eof  = out_dat_q[Bw_d];
    assign rd_vld  = out_vld_q;
    assign frm_cnt = frm_cnt_q;
    assign drp_cnt = drp_cnt_q;

endmodule

// File: tb/tb_ss_pkt_fifo_sync.sv
// Directed bench for ss_pkt_fifo_sync with a 16-word buffer.
module tb_ss_pkt_fifo_sync;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_di;
    logic       wr_en;
    logic       wr_eof;
    logic       wr_bad;
    logic       wr_rdy;
    logic [7:0] rd_do;
    logic       rd_eof;
    logic       rd_vld;
    logic       rd_en;
    logic [4:0] frm_cnt;
    logic [15:0] drp_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Expected read words {eof, data}, pushed when a good frame is written.
    logic [8:0] exp_q[$];

    ss_pkt_fifo_sync #(
        .Bw_d(8), .Bw_a(4), .Thrs_wr(12), .Bw_c(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_di(wr_di), .wr_en(wr_en), .wr_eof(wr_eof), .wr_bad(wr_bad),
        .wr_rdy(wr_rdy),
        .rd_do(rd_do), .rd_eof(rd_eof), .rd_vld(rd_vld), .rd_en(rd_en),
        .frm_cnt(frm_cnt), .drp_cnt(drp_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [7:0] d, input logic eof, input logic bad);
        wr_di  = d;
        wr_eof = eof;
        wr_bad = bad;
        wr_en  = 1'b1;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        wr_eof = 1'b0;
        wr_bad = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic write_frame(input logic [7:0] base, input int len, input logic bad);
        for (int i = 0; i < len; i++) begin
            write_word(base + 8'(i), (i == len - 1), bad && (i == len - 1));
        end
    endtask

    // Scoreboard: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && rd_vld && rd_en) begin
            if (exp_q.size() == 0) begin
                check_eq("rd_unexpected", {31'd0, rd_vld}, 32'd0);
            end else begin
                check_eq("rd_word", {23'd0, rd_eof, rd_do}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        wr_di   = '0;
        wr_en   = 1'b0;
        wr_eof  = 1'b0;
        wr_bad  = 1'b0;
        rd_en   = 1'b0;
        idle(2);
        check_eq("rst_rd_vld", {31'd0, rd_vld}, 32'd0);
        check_eq("rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        check_eq("rst_frm_cnt", {27'd0, frm_cnt}, 32'd0);
        check_eq("rst_drp_cnt", {16'd0, drp_cnt}, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // 1: good 3-word frame, reader always ready.
        rd_en = 1'b1;
        push_frame(8'hA0, 3);
        write_frame(8'hA0, 3, 1'b0);
        check_eq("t1_frm_after_eof", {27'd0, frm_cnt}, 32'd1);
        check_eq("t1_vld_eof_plus0", {31'd0, rd_vld}, 32'd0);
        idle(1);
        check_eq("t1_vld_eof_plus1", {31'd0, rd_vld}, 32'd0);
        idle(1);
        check_eq("t1_vld_eof_plus2", {31'd0, rd_vld}, 32'd1);
        check_eq("t1_first_word", {24'd0, rd_do}, 32'hA0);
        idle(1);
        check_eq("t1_vld_second", {31'd0, rd_vld}, 32'd1);
        check_eq("t1_second_word", {24'd0, rd_do}, 32'hA1);
        idle(1);
        check_eq("t1_third_eof", {31'd0, rd_eof}, 32'd1);
        check_eq("t1_third_word", {24'd0, rd_do}, 32'hA2);
        idle(1);
        check_eq("t1_frm_drained", {27'd0, frm_cnt}, 32'd0);
        check_eq("t1_vld_drained", {31'd0, rd_vld}, 32'd0);

        // 2: bad 4-word frame is discarded, following good frame passes.
        write_frame(8'h90, 4, 1'b1);
        check_eq("t2_wr_eq_cm", {27'd0, dut.wr_ad_q}, {27'd0, dut.cm_ad_q});
        check_eq("t2_wr_ad", {27'd0, dut.wr_ad_q}, 32'd3);
        check_eq("t2_drp_cnt", {16'd0, drp_cnt}, 32'd1);
        check_eq("t2_frm_cnt", {27'd0, frm_cnt}, 32'd0);
        push_frame(8'hB0, 2);
        write_frame(8'hB0, 2, 1'b0);
        idle(6);
        check_eq("t2_frm_drained", {27'd0, frm_cnt}, 32'd0);

        // 3: fill with 16-word frame while stalled; next frame overflows.
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_word(8'h40 + 8'(i), (i == 15), 1'b0);
            if (i == 11) check_eq("t3_rdy_at_12", {31'd0, wr_rdy}, 32'd1);
            if (i == 12) check_eq("t3_rdy_at_13", {31'd0, wr_rdy}, 32'd0);
        end
        check_eq("t3_used_full", {27'd0, dut.used}, 32'd16);
        check_eq("t3_frm_cnt", {27'd0, frm_cnt}, 32'd1);
        write_frame(8'hD0, 2, 1'b0);
        check_eq("t3_drp_cnt", {16'd0, drp_cnt}, 32'd2);
        check_eq("t3_used_after_drop", {27'd0, dut.used}, 32'd14);
        check_eq("t3_rdy_after_drop", {31'd0, wr_rdy}, 32'd0);
        check_eq("t3_frm_after_drop", {27'd0, frm_cnt}, 32'd1);
        push_frame(8'h40, 16);
        rd_en = 1'b1;
        idle(20);
        check_eq("t3_frm_drained", {27'd0, frm_cnt}, 32'd0);
        check_eq("t3_used_drained", {27'd0, dut.used}, 32'd0);

        // 4: 20-word frame cannot fit and is dropped.
        for (int i = 0; i < 20; i++) begin
            write_word(8'h60 + 8'(i), (i == 19), 1'b0);
            if (i == 15) check_eq("t4_used_16", {27'd0, dut.used}, 32'd16);
        end
        check_eq("t4_used_zero", {27'd0, dut.used}, 32'd0);
        check_eq("t4_frm_cnt", {27'd0, frm_cnt}, 32'd0);
        check_eq("t4_drp_cnt", {16'd0, drp_cnt}, 32'd3);
        idle(4);
        check_eq("t4_no_vld", {31'd0, rd_vld}, 32'd0);
        check_eq("t4_rdy", {31'd0, wr_rdy}, 32'd1);

        // 5: reader stall holds output; commit coincides with eof transfer.
        rd_en = 1'b0;
        push_frame(8'hE0, 4);
        push_frame(8'hF0, 3);
        write_frame(8'hE0, 4, 1'b0);
        idle(3);
        check_eq("t5_vld_e0", {31'd0, rd_vld}, 32'd1);
        check_eq("t5_do_e0", {24'd0, rd_do}, 32'hE0);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) write_word(8'hF0, 1'b0, 1'b0);
            else if (i == 2) write_word(8'hF1, 1'b0, 1'b0);
            else idle(1);
            check_eq("t5_hold_do", {24'd0, rd_do}, 32'hE1);
            check_eq("t5_hold_vld", {31'd0, rd_vld}, 32'd1);
        end
        check_eq("t5_frm_before", {27'd0, frm_cnt}, 32'd1);
        rd_en = 1'b1;
        idle(2);
        check_eq("t5_eof_present", {31'd0, rd_eof}, 32'd1);
        check_eq("t5_do_e3", {24'd0, rd_do}, 32'hE3);
        write_word(8'hF2, 1'b1, 1'b0);
        check_eq("t5_frm_same_cycle", {27'd0, frm_cnt}, 32'd1);
        idle(10);
        check_eq("t5_frm_drained", {27'd0, frm_cnt}, 32'd0);

        // 6: asynchronous reset with two frames queued and one partial.
        rd_en = 1'b0;
        write_frame(8'h11, 2, 1'b0);
        write_frame(8'h21, 2, 1'b0);
        write_word(8'h31, 1'b0, 1'b0);
        idle(2);
        check_eq("t6_frm_queued", {27'd0, frm_cnt}, 32'd2);
        check_eq("t6_vld_queued", {31'd0, rd_vld}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_vld", {31'd0, rd_vld}, 32'd0);
        check_eq("t6_rst_frm", {27'd0, frm_cnt}, 32'd0);
        check_eq("t6_rst_drp", {16'd0, drp_cnt}, 32'd0);
        check_eq("t6_rst_rdy", {31'd0, wr_rdy}, 32'd1);
        check_eq("t6_rst_do", {23'd0, rd_eof, rd_do}, 32'd0);
        exp_q.delete();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        rd_en = 1'b1;
        push_frame(8'hC0, 3);
        write_frame(8'hC0, 3, 1'b0);
        idle(8);
        check_eq("t6_frm_drained", {27'd0, frm_cnt}, 32'd0);
        check_eq("t6_drp_after", {16'd0, drp_cnt}, 32'd0);
        check_eq("exp_q_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
